// File: rtl/timepulse_generator_if.sv
// Control and timepulse signal bundle for timepulse_generator.
// master drives the stop/step/restart controls; slave produces the timepulses.
interface timepulse_generator_if #(
  parameter int unsigned CNT_W = 16
);
  logic             GOJAM;
  logic             MSTP;
  logic             MSTRT;
  logic [11:0]      T_n;
  logic             CT_n;
  logic             RT_n;
  logic             WT_n;
  logic             TT_n;
  logic             P04_n;
  logic             T10_n;
  logic             STOPPED;
  logic [CNT_W-1:0] MCTCNT;

  modport master (
    output GOJAM, MSTP, MSTRT,
    input  T_n, CT_n, RT_n, WT_n, TT_n, P04_n, T10_n, STOPPED, MCTCNT
  );

  modport slave (
    input  GOJAM, MSTP, MSTRT,
    output T_n, CT_n, RT_n, WT_n, TT_n, P04_n, T10_n, STOPPED, MCTCNT
  );
endinterface

// File: rtl/timepulse_generator.sv
// Twelve-timepulse, four-phase memory-cycle sequencer with stop, single-step
// and GOJAM restart; every output comes straight from a flop.
module timepulse_generator #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  SIM_CLK,
  input  logic                  SIM_RST,
  timepulse_generator_if.slave  bus
);

  localparam int unsigned TP_W   = 4;
  localparam int unsigned PH_W   = 2;
  localparam int unsigned NUM_TP = 12;
  localparam logic [TP_W-1:0] TP_LAST = TP_W'(NUM_TP - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(3);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [TP_W-1:0]   tp_q, tp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mstrt_q, mstrt_d;
  logic [NUM_TP-1:0] t_n_q, t_n_d;
  logic              ct_n_q, ct_n_d;
  logic              rt_n_q, rt_n_d;
  logic              wt_n_q, wt_n_d;
  logic              tt_n_q, tt_n_d;
  logic              p04_n_q, p04_n_d;
  logic              stopped_q, stopped_d;

  logic mct_end;
  logic mstrt_rise;
  logic running_d;

  // Sequencing and stop/step control
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    tp_d       = tp_q;
    cnt_d      = cnt_q;
    mstrt_d    = bus.MSTRT;
    mct_end    = (tp_q == TP_LAST) && (phase_q == PH_LAST);
    mstrt_rise = bus.MSTRT && !mstrt_q;

    if (bus.GOJAM) begin
      mstrt_d = 1'b0;
      unique case (state_q)
        ST_RUN: begin
          phase_d = '0;
          tp_d    = '0;
        end
        ST_STEP: begin
          phase_d = '0;
          tp_d    = '0;
          state_d = bus.MSTP ? ST_HALT : ST_RUN;
        end
        ST_HALT: ;
        default: state_d = ST_RUN;
      endcase
    end else begin
      unique case (state_q)
        ST_HALT: begin
          if (!bus.MSTP)       state_d = ST_RUN;
          else if (mstrt_rise) state_d = ST_STEP;
        end
        ST_RUN, ST_STEP: begin
          phase_d = phase_q + PH_W'(1);
          if (phase_q == PH_LAST) tp_d = mct_end ? '0 : tp_q + TP_W'(1);
          // A completed MCT is the only point where a stop request is honoured
          if (mct_end) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = bus.MSTP ? ST_HALT : ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    running_d = (state_d != ST_HALT);
    t_n_d     = running_d ? ~(NUM_TP'(1) << tp_d) : '1;
    ct_n_d    = !(running_d && (phase_d == PH_W'(0)));
    rt_n_d    = !(running_d && (phase_d == PH_W'(1)));
    wt_n_d    = !(running_d && (phase_d == PH_W'(2)));
    tt_n_d    = !(running_d && ((phase_d == PH_W'(1)) || (phase_d == PH_W'(2))));
    p04_n_d   = !(running_d && (phase_d == PH_LAST));
    stopped_d = !running_d;
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_q   <= ST_RUN;
      phase_q   <= '0;
      tp_q      <= '0;
      cnt_q     <= '0;
      mstrt_q   <= 1'b0;
      t_n_q     <= 12'hFFE;
      ct_n_q    <= 1'b0;
      rt_n_q    <= 1'b1;
      wt_n_q    <= 1'b1;
      tt_n_q    <= 1'b1;
      p04_n_q   <= 1'b1;
      stopped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      tp_q      <= tp_d;
      cnt_q     <= cnt_d;
      mstrt_q   <= mstrt_d;
      t_n_q     <= t_n_d;
      ct_n_q    <= ct_n_d;
      rt_n_q    <= rt_n_d;
      wt_n_q    <= wt_n_d;
      tt_n_q    <= tt_n_d;
      p04_n_q   <= p04_n_d;
      stopped_q <= stopped_d;
    end
  end

  assign bus.T_n     = t_n_q;
  assign bus.T10_n   = t_n_q[9];
  assign bus.CT_n    = ct_n_q;
  assign bus.RT_n    = rt_n_q;
  assign bus.WT_n    = wt_n_q;
  assign bus.TT_n    = tt_n_q;
  assign bus.P04_n   = p04_n_q;
  assign bus.STOPPED = stopped_q;
  assign bus.MCTCNT  = cnt_q;

endmodule

// File: tb/tb_timepulse_generator.sv
// Bench for timepulse_generator: directed scenarios plus random control traffic,
// compared each cycle against a position-in-MCT reference model.
module tb_timepulse_generator;

  logic clk;
  logic rst_n;
  logic gojam, mstp, mstrt;

  timepulse_generator_if #(.CNT_W(16)) bus16 ();
  timepulse_generator_if #(.CNT_W(4))  bus4 ();

  assign bus16.GOJAM = gojam;
  assign bus16.MSTP  = mstp;
  assign bus16.MSTRT = mstrt;
  assign bus4.GOJAM  = gojam;
  assign bus4.MSTP   = mstp;
  assign bus4.MSTRT  = mstrt;

  timepulse_generator #(.CNT_W(16)) u_dut16 (.SIM_CLK(clk), .SIM_RST(rst_n), .bus(bus16));
  timepulse_generator #(.CNT_W(4))  u_dut4  (.SIM_CLK(clk), .SIM_RST(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: mode 0=run 1=halt 2=step; pos = clock index 0..47 in MCT
  int m_mode, m_pos, m_cnt;
  bit m_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_cnt = 0; m_prev = 1'b0;
  endtask

  task automatic model_step(input bit g, input bit s, input bit m);
    bit rise;
    rise   = m && !m_prev;
    m_prev = g ? 1'b0 : m;
    if (g) begin
      if (m_mode != 1) begin
        m_pos = 0;
        if (m_mode == 2) m_mode = s ? 1 : 0;
      end
    end else if (m_mode == 1) begin
      if (!s)        begin m_mode = 0; m_pos = 0; end
      else if (rise) begin m_mode = 2; m_pos = 0; end
    end else if (m_pos == 47) begin
      m_cnt++;
      m_pos  = 0;
      m_mode = s ? 1 : 0;
    end else begin
      m_pos++;
    end
  endtask

  task automatic compare_all();
    bit run;
    int ph;
    logic [11:0] exp_t;
    run   = (m_mode != 1);
    ph    = m_pos % 4;
    exp_t = run ? ~(12'h001 << (m_pos / 4)) : 12'hFFF;
    check("T_n",     32'(bus16.T_n),     32'(exp_t));
    check("T10_n",   32'(bus16.T10_n),   32'(exp_t[9]));
    check("CT_n",    32'(bus16.CT_n),    32'(!(run && ph == 0)));
    check("RT_n",    32'(bus16.RT_n),    32'(!(run && ph == 1)));
    check("WT_n",    32'(bus16.WT_n),    32'(!(run && ph == 2)));
    check("TT_n",    32'(bus16.TT_n),    32'(!(run && (ph == 1 || ph == 2))));
    check("P04_n",   32'(bus16.P04_n),   32'(!(run && ph == 3)));
    check("STOPPED", 32'(bus16.STOPPED), 32'(!run));
    check("MCTCNT",  32'(bus16.MCTCNT),  32'(m_cnt % 65536));
    check("MCTCNT4", 32'(bus4.MCTCNT),   32'(m_cnt % 16));
  endtask

  // Drive inputs at the falling edge, clock once, compare at the next falling edge
  task automatic cycle(input bit g, input bit s, input bit m);
    gojam = g; mstp = s; mstrt = m;
    @(posedge clk);
    model_step(g, s, m);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (!(m_mode != 1 && m_pos == target) && n < 200) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (n >= 200) check("run_to_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    int running;
    int n;
    rst_n = 1'b0; gojam = 1'b0; mstp = 1'b0; mstrt = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Free run through 16 MCTs: narrow counter must wrap to zero
    for (int i = 0; i < 16 * 48; i++) cycle(1'b0, 1'b0, 1'b0);
    check("wrap_cnt4",  32'(bus4.MCTCNT),  32'(0));
    check("wrap_cnt16", 32'(bus16.MCTCNT), 32'(16));

    // Stop requested at T05, honoured only after T12
    run_to(16);
    n = 0;
    while (m_mode != 1 && n < 100) begin cycle(1'b0, 1'b1, 1'b0); n++; end
    check("stop_reached", 32'(bus16.STOPPED), 32'(1));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0);

    // Single step with a second MSTRT pulse mid-step that must be ignored
    running = 0;
    cycle(1'b0, 1'b1, 1'b1);
    if (bus16.STOPPED == 1'b0) running++;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 1'b1, (i == 10 || i == 11));
      if (bus16.STOPPED == 1'b0) running++;
    end
    check("step_len", 32'(running), 32'(48));

    // GOJAM while halted keeps the halt; then release and restart via GOJAM mid-MCT
    cycle(1'b1, 1'b1, 1'b0);
    check("gojam_halt", 32'(bus16.STOPPED), 32'(1));
    cycle(1'b0, 1'b0, 1'b0);
    check("resume_t01", 32'(bus16.T_n), 32'(12'hFFE));
    run_to(26);
    cycle(1'b1, 1'b0, 1'b0);
    check("gojam_t01", 32'(bus16.T_n), 32'(12'hFFE));

    // Asynchronous reset at T09 phase 3, between clock edges
    run_to(35);
    #2 rst_n = 1'b0;
    #1;
    check("arst_T_n",    32'(bus16.T_n),     32'(12'hFFE));
    check("arst_CT_n",   32'(bus16.CT_n),    32'(0));
    check("arst_P04_n",  32'(bus16.P04_n),   32'(1));
    check("arst_MCTCNT", 32'(bus16.MCTCNT),  32'(0));
    check("arst_STOP",   32'(bus16.STOPPED), 32'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Random control traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) mstp = ~mstp;
      cycle($urandom_range(0, 99) == 0, mstp, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
